// File: rtl/irda_pkg.sv
// Shared types and sizing helpers for the IrDA SIR receive front-end.
// Holds the FSM state enum, bit-time derivation and counter-width function.
package irda_pkg;

   localparam int GLITCH_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      HOLD,
      BLANK
   } state_e;

   function automatic int bit_cycles_f(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int cnt_width_f(input int bit_cycles);
      return $clog2(bit_cycles + 1);
   endfunction

endpackage

// File: rtl/irda_sir_pulse_decoder_if.sv
// Pulse-side and NRZ-side signal bundle of the SIR pulse decoder.
// master: IR front/transmitter side (drives ir_in, tx_busy); slave: decoder.
interface irda_sir_pulse_decoder_if;
   import irda_pkg::*;

   logic                ir_in;
   logic                tx_busy;
   logic                nrz_out;
   logic                rx_active;
   logic                pulse_err;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output ir_in,
      output tx_busy,
      input  nrz_out,
      input  rx_active,
      input  pulse_err,
      input  glitch_cnt
   );

   modport slave (
      input  ir_in,
      input  tx_busy,
      output nrz_out,
      output rx_active,
      output pulse_err,
      output glitch_cnt
   );

endinterface

// File: rtl/irda_sir_pulse_decoder_bit_sync.sv
// bit_sync: 2-FF synchroniser for one asynchronous bit.
// Ports: clock, reset (sync, active-low), d_i async in, q_o synced out.
module bit_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   assign sync_d = {sync_q[0], d_i};

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_q <= {2{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/irda_sir_pulse_decoder.sv
// IrDA SIR pulse decoder: syncs ir_in, rejects glitches, stretches each
// qualified pulse into a BIT_CYCLES-long low NRZ bit for the byte receiver.
// Ports: clock, reset (sync, active-low), bus (slave): ir_in, tx_busy in;
// nrz_out, rx_active, pulse_err, glitch_cnt out.
// Optional echo blanking on tx_busy when IRDA_RX_BLANK_EN is defined.
module irda_sir_pulse_decoder
   import irda_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int BAUD          = 9600,
   parameter int MIN_PULSE     = 200,
   parameter int BLANK_CYCLES  = 5208,
   parameter int IR_ACTIVE_LOW = 1
) (
   input logic                     clock,
   input logic                     reset,
   irda_sir_pulse_decoder_if.slave bus
);

   localparam int BIT_CYCLES = bit_cycles_f(CLK_HZ, BAUD);
   localparam int CW         = cnt_width_f(BIT_CYCLES);

   localparam logic [CW-1:0] BIT_CNT = CW'(BIT_CYCLES);
   localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PULSE);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic          ACT_LO  = (IR_ACTIVE_LOW != 0);

   logic                ir_sync;
   logic                p;
   logic                p_prev_q;
   logic                rise;
   logic                qual;
   logic                blank;

   state_e              state_q, state_d;
   logic [CW-1:0]       width_q, width_d;
   logic [CW-1:0]       win_q, win_d;
   logic                err_done_q, err_done_d;
   logic                pulse_err_q, pulse_err_d;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;
   logic                nrz_q, nrz_d;
   logic                rx_active_q, rx_active_d;

   // Idle line level resets into the synchroniser so p starts at 0.
   bit_sync #(
      .RST_VAL (ACT_LO)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (bus.ir_in),
      .q_o   (ir_sync)
   );

   assign p    = ACT_LO ? ~ir_sync : ir_sync;
   assign rise = p & ~p_prev_q;

`ifdef IRDA_RX_BLANK_EN
   localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

   logic [CW-1:0] blank_q, blank_d;

   assign blank = bus.tx_busy | (state_q == BLANK);

   // Guard time restarts while transmitting, then runs down after tx ends.
   always_comb begin
      blank_d = blank_q;
      if (bus.tx_busy) begin
         blank_d = BLANK_CNT;
      end else if (state_q == BLANK && blank_q != '0) begin
         blank_d = blank_q - ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end
`else
   logic unused_tx;
   localparam int unused_blank = BLANK_CYCLES;

   assign unused_tx = bus.tx_busy;
   assign blank     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      err_done_d  = err_done_q;
      pulse_err_d = 1'b0;
      glitch_d    = glitch_q;
      qual        = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The rising cycle itself is the first counted cycle of width.
            if (rise) begin
               state_d = MEASURE;
               width_d = ONE;
            end
         end
         MEASURE: begin
            if (!p) begin
               if (glitch_q != '1) begin
                  glitch_d = glitch_q + 1'b1;
               end
               state_d = IDLE;
            end else begin
               width_d = width_q + ONE;
               if (width_q + ONE == MIN_CNT) begin
                  qual    = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (!p) begin
               state_d    = IDLE;
               err_done_d = 1'b0;
            end else if (width_q == BIT_CNT) begin
               // Width parks at BIT_CYCLES; the flag limits to one strobe.
               if (!err_done_q) begin
                  pulse_err_d = 1'b1;
                  err_done_d  = 1'b1;
               end
            end else begin
               width_d = width_q + ONE;
            end
         end
         BLANK: begin
`ifdef IRDA_RX_BLANK_EN
            if (!bus.tx_busy && blank_q == '0 && !p) begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef IRDA_RX_BLANK_EN
      if (bus.tx_busy) begin
         state_d     = BLANK;
         width_d     = '0;
         err_done_d  = 1'b0;
         pulse_err_d = 1'b0;
         glitch_d    = glitch_q;
         qual        = 1'b0;
      end
`endif
   end

   // Output window: a qualification always reloads, so back-to-back zeros
   // join without a high gap. A stuck (over-long) pulse keeps it reloaded
   // so the line stays low until one bit time after release.
   always_comb begin
      win_d = win_q;
      if (blank) begin
         win_d = '0;
      end else if (qual) begin
         win_d = BIT_CNT;
      end else if (state_q == HOLD && p && err_done_q) begin
         win_d = BIT_CNT;
      end else if (win_q != '0) begin
         win_d = win_q - ONE;
      end
      nrz_d       = (win_d == '0);
      rx_active_d = (state_d == MEASURE) || (state_d == HOLD) ||
                    (win_d != '0);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         p_prev_q    <= 1'b0;
         width_q     <= '0;
         win_q       <= '0;
         err_done_q  <= 1'b0;
         pulse_err_q <= 1'b0;
         glitch_q    <= '0;
         nrz_q       <= 1'b1;
         rx_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_prev_q    <= p;
         width_q     <= width_d;
         win_q       <= win_d;
         err_done_q  <= err_done_d;
         pulse_err_q <= pulse_err_d;
         glitch_q    <= glitch_d;
         nrz_q       <= nrz_d;
         rx_active_q <= rx_active_d;
      end
   end

   assign bus.nrz_out    = nrz_q;
   assign bus.rx_active  = rx_active_q;
   assign bus.pulse_err  = pulse_err_q;
   assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_irda_sir_pulse_decoder.sv
// Directed self-checking bench for irda_sir_pulse_decoder (default params,
// active-low IR input); blanking checks follow IRDA_RX_BLANK_EN.
module tb_irda_sir_pulse_decoder;

   localparam int BITC = 5208;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   irda_sir_pulse_decoder_if bus ();

   irda_sir_pulse_decoder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic act);
      bus.ir_in = act ? 1'b0 : 1'b1;
   endtask

   // Pulse k is active for samples k*per+1 .. k*per+on; edge i observed.
   task automatic run(input int on, input int per, input int npulse,
                      input int total, output int first_low,
                      output int last_low, output int low_cnt,
                      output int err_cnt, output int err_at,
                      output logic rx_mid);
      first_low = -1;
      last_low  = -1;
      low_cnt   = 0;
      err_cnt   = 0;
      err_at    = -1;
      rx_mid    = 1'b0;
      drive(1'b1);
      for (int i = 1; i <= total; i++) begin
         tick(1);
         if (bus.nrz_out === 1'b0) begin
            if (first_low < 0) first_low = i;
            last_low = i;
            low_cnt++;
         end
         if (bus.pulse_err === 1'b1) begin
            err_cnt++;
            err_at = i;
         end
         if (i == 100) rx_mid = bus.rx_active;
         if (i % per == on) drive(1'b0);
         if (i % per == 0 && i / per < npulse) drive(1'b1);
      end
      drive(1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      tick(3);
      tests++;
      if (bus.nrz_out !== 1'b1) begin
         fails++;
         $display("FAIL reset_nrz got %b want 1", bus.nrz_out);
      end
      tests++;
      if (bus.rx_active !== 1'b0) begin
         fails++;
         $display("FAIL reset_rx got %b want 0", bus.rx_active);
      end
      tests++;
      if (bus.pulse_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_err got %b want 0", bus.pulse_err);
      end
      tests++;
      if (bus.glitch_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_glitch got %0d want 0", bus.glitch_cnt);
      end
      reset = 1'b1;
      tick(5);
   endtask

   task automatic test_isolated;
      int f, l, c, e, ea;
      logic rm;
      run(976, 100000, 1, 6000, f, l, c, e, ea, rm);
      tests++;
      if (f != 202) begin
         fails++;
         $display("FAIL iso_fall got %0d want 202", f);
      end
      tests++;
      if (c != BITC || l != 5409) begin
         fails++;
         $display("FAIL iso_len got %0d/%0d want %0d/5409", c, l, BITC);
      end
      tests++;
      if (e != 0 || bus.glitch_cnt !== 8'd0) begin
         fails++;
         $display("FAIL iso_err got %0d/%0d want 0/0", e, bus.glitch_cnt);
      end
      tests++;
      if (rm !== 1'b1 || bus.rx_active !== 1'b0) begin
         fails++;
         $display("FAIL iso_rx got %b/%b want 1/0", rm, bus.rx_active);
      end
   endtask

   task automatic test_glitch;
      int f, l, c, e, ea;
      logic rm;
      logic g152, g153, low;
      g152 = 1'b0;
      g153 = 1'b0;
      low  = 1'b0;
      drive(1'b1);
      for (int i = 1; i <= 160; i++) begin
         tick(1);
         if (bus.nrz_out !== 1'b1) low = 1'b1;
         if (i == 152) g152 = (bus.glitch_cnt == 8'd0);
         if (i == 153) g153 = (bus.glitch_cnt == 8'd1);
         if (i == 150) drive(1'b0);
      end
      tests++;
      if (!g152 || !g153) begin
         fails++;
         $display("FAIL glitch_timing got %b%b want 11", g152, g153);
      end
      tests++;
      if (low) begin
         fails++;
         $display("FAIL glitch_nrz got low want high");
      end
      run(199, 100000, 1, 400, f, l, c, e, ea, rm);
      tests++;
      if (c != 0 || bus.glitch_cnt !== 8'd2) begin
         fails++;
         $display("FAIL glitch_199 got %0d/%0d want 0/2", c, bus.glitch_cnt);
      end
      run(200, 100000, 1, 5600, f, l, c, e, ea, rm);
      tests++;
      if (f != 202 || c != BITC || bus.glitch_cnt !== 8'd2) begin
         fails++;
         $display("FAIL qual_200 got %0d/%0d/%0d want 202/%0d/2",
                  f, c, bus.glitch_cnt, BITC);
      end
      run(20, 30, 300, 9010, f, l, c, e, ea, rm);
      tests++;
      if (c != 0 || bus.glitch_cnt !== 8'd255) begin
         fails++;
         $display("FAIL glitch_sat got %0d/%0d want 0/255",
                  c, bus.glitch_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int f, l, c, e, ea;
      logic rm;
      run(976, BITC, 4, 21500, f, l, c, e, ea, rm);
      tests++;
      if (f != 202 || l != 21033) begin
         fails++;
         $display("FAIL b2b_span got %0d..%0d want 202..21033", f, l);
      end
      tests++;
      if (c != 4 * BITC) begin
         fails++;
         $display("FAIL b2b_gap got %0d want %0d", c, 4 * BITC);
      end
   endtask

   task automatic test_stuck;
      int f, l, c, e, ea;
      logic rm;
      run(12000, 100000, 1, 17500, f, l, c, e, ea, rm);
      tests++;
      if (e != 1 || ea != 5211) begin
         fails++;
         $display("FAIL stuck_err got %0d@%0d want 1@5211", e, ea);
      end
      tests++;
      if (f != 202 || l != 17209 || c != 17008) begin
         fails++;
         $display("FAIL stuck_nrz got %0d..%0d n%0d want 202..17209 n17008",
                  f, l, c);
      end
   endtask

   task automatic test_reset_mid;
      int f, l, c, e, ea;
      logic rm;
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(3);
      run(150, 100000, 1, 200, f, l, c, e, ea, rm);
      drive(1'b1);
      for (int i = 1; i <= 1202; i++) begin
         tick(1);
         if (i == 300) drive(1'b0);
      end
      tests++;
      if (bus.nrz_out !== 1'b0 || bus.glitch_cnt !== 8'd1) begin
         fails++;
         $display("FAIL mid_pre got %b/%0d want 0/1",
                  bus.nrz_out, bus.glitch_cnt);
      end
      reset = 1'b0;
      tick(1);
      tests++;
      if (bus.nrz_out !== 1'b1 || bus.rx_active !== 1'b0 ||
          bus.glitch_cnt !== 8'd0) begin
         fails++;
         $display("FAIL mid_reset got %b/%b/%0d want 1/0/0",
                  bus.nrz_out, bus.rx_active, bus.glitch_cnt);
      end
      reset = 1'b1;
      tick(3);
      run(300, 100000, 1, 5600, f, l, c, e, ea, rm);
      tests++;
      if (f != 202 || c != BITC) begin
         fails++;
         $display("FAIL mid_after got %0d/%0d want 202/%0d", f, c, BITC);
      end
   endtask

   task automatic test_blank;
      int f, l, c, e, ea;
      logic rm;
`ifdef IRDA_RX_BLANK_EN
      logic [7:0] g0;
      g0 = bus.glitch_cnt;
      bus.tx_busy = 1'b1;
      tick(2);
      run(976, 100000, 1, 2000, f, l, c, e, ea, rm);
      tests++;
      if (c != 0) begin
         fails++;
         $display("FAIL blank_busy got %0d low want 0", c);
      end
      run(150, 100000, 1, 300, f, l, c, e, ea, rm);
      tests++;
      if (bus.glitch_cnt !== g0) begin
         fails++;
         $display("FAIL blank_glitch got %0d want %0d", bus.glitch_cnt, g0);
      end
      bus.tx_busy = 1'b0;
      run(976, 100000, 1, 1000, f, l, c, e, ea, rm);
      tests++;
      if (c != 0) begin
         fails++;
         $display("FAIL blank_guard got %0d low want 0", c);
      end
      tick(5000);
      run(976, 100000, 1, 5600, f, l, c, e, ea, rm);
      tests++;
      if (f != 202 || c != BITC || bus.glitch_cnt !== g0) begin
         fails++;
         $display("FAIL blank_after got %0d/%0d/%0d want 202/%0d/%0d",
                  f, c, bus.glitch_cnt, BITC, g0);
      end
`else
      bus.tx_busy = 1'b1;
      run(976, 100000, 1, 5600, f, l, c, e, ea, rm);
      bus.tx_busy = 1'b0;
      tests++;
      if (f != 202 || c != BITC) begin
         fails++;
         $display("FAIL txbusy_ignored got %0d/%0d want 202/%0d",
                  f, c, BITC);
      end
`endif
   endtask

   initial begin
      bus.ir_in   = 1'b1;
      bus.tx_busy = 1'b0;
      test_reset();
      test_isolated();
      test_glitch();
      test_back_to_back();
      test_stuck();
      test_reset_mid();
      test_blank();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
